wmt_gen: RTL and testbench

Water meter flow-pulse generator. It drives a programmable square wave that is the mirror of the water meter detector's input. Period and high time are set in microseconds, counted on the 1 µs tick clock, and the pulse train can be continuous or a counted burst. It sits on the self-test path and loops its output into the detector input, so period limits and duty checks can be exercised without a real meter.

---
 rtl/wmt_gen_if.sv | 25 ++
 rtl/wmt_gen.sv | 177 +++++++++++++++++
 tb/tb_wmt_gen.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wmt_gen_if.sv
// wmt_gen_if -- control, configuration and status bundle of the water meter
// flow-pulse generator. The master side is the self-test controller that
// programs and starts the generator; the slave side is wmt_gen itself.
interface wmt_gen_if;
   logic        gen_en;
   logic        cfg_ld;
   logic [15:0] pdn1us_set;
   logic [15:0] pdnh1us_set;
   logic [7:0]  ncyc_set;
   logic        wmt_sig_o;
   logic        gen_busy;
   logic        cyc_done;
   logic [7:0]  cyc_cnt;
   logic        cfg_err;

   modport master (
      output gen_en, cfg_ld, pdn1us_set, pdnh1us_set, ncyc_set,
      input  wmt_sig_o, gen_busy, cyc_done, cyc_cnt, cfg_err
   );

   modport slave (
      input  gen_en, cfg_ld, pdn1us_set, pdnh1us_set, ncyc_set,
      output wmt_sig_o, gen_busy, cyc_done, cyc_cnt, cfg_err
   );
endinterface

// File: rtl/wmt_gen.sv
// wmt_gen -- water meter flow-pulse generator. Produces a square wave whose
// period and high time are counted in 1 us ticks, looped back into the meter
// detector during self-test. Optional macro WMT_GEN_BURST_EN adds counted
// bursts (ncyc_set periods, then stop); without it the train is continuous.
module wmt_gen #(
   parameter logic [15:0] WMT_PDN_MAX = 16'd25000,
   parameter logic [15:0] WMT_PDN_MIN = 16'd2
) (
   input logic       clk_1us,
   input logic       rst_i,
   wmt_gen_if.slave  wif
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, STOP} state_t;

   state_t      state_q, state_d;
   logic        gen_en_q;
   logic [15:0] p_q, h_q;
   logic [15:0] p_eff, h_eff;
   logic [15:0] ha_q, ha_d;
   logic [15:0] la_q, la_d;
   logic [15:0] ph_q, ph_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        sig_q, sig_d;
   logic        cfg_legal;
   logic        load_c;
   logic        done_c;
   logic        start_ok;
   logic        burst_last;

   // A cfg_ld coinciding with a reload point wins: the reload sees the new values
   assign p_eff = wif.cfg_ld ? wif.pdn1us_set  : p_q;
   assign h_eff = wif.cfg_ld ? wif.pdnh1us_set : h_q;

   assign cfg_legal = (p_eff >= WMT_PDN_MIN) && (p_eff <= WMT_PDN_MAX) &&
                      (h_eff != 16'd0) && (h_eff < p_eff);

   // Shadow period/high-time registers, written only by the load strobe
   always_ff @(posedge clk_1us) begin
      if (rst_i) begin
         p_q <= 16'd1000;
         h_q <= 16'd500;
      end else if (wif.cfg_ld) begin
         p_q <= wif.pdn1us_set;
         h_q <= wif.pdnh1us_set;
      end
   end

`ifdef WMT_GEN_BURST_EN
   logic [7:0] n_q, n_eff, na_q, na_d;
   logic       hold_q, hold_d;

   assign n_eff      = wif.cfg_ld ? wif.ncyc_set : n_q;
   assign start_ok   = ~hold_q;
   assign burst_last = (na_q != 8'd0) && (({1'b0, cnt_q} + 9'd1) == {1'b0, na_q});

   // Burst length reloads with the other active registers; hold blocks restart until gen_en drops
   always_comb begin
      na_d   = load_c ? n_eff : na_q;
      hold_d = (done_c & burst_last) | (hold_q & gen_en_q);
   end

   // Burst shadow, active burst length and post-burst restart lock
   always_ff @(posedge clk_1us) begin
      if (rst_i) begin
         n_q    <= 8'd0;
         na_q   <= 8'd0;
         hold_q <= 1'b0;
      end else begin
         if (wif.cfg_ld) n_q <= wif.ncyc_set;
         na_q   <= na_d;
         hold_q <= hold_d;
      end
   end
`else
   logic unused_ncyc;

   assign unused_ncyc = ^wif.ncyc_set;
   assign start_ok    = 1'b1;
   assign burst_last  = 1'b0;
`endif

   // Next-state, phase counting, period completion and error flag
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      load_c  = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         IDLE: begin
            ph_d = 16'd0;
            if (!gen_en_q) begin
               err_d = 1'b0;
            end else if (!cfg_legal) begin
               err_d = 1'b1;
            end else begin
               err_d = 1'b0;
               if (start_ok) begin
                  state_d = HIGH;
                  ph_d    = 16'd1;
                  cnt_d   = 8'd0;
                  load_c  = 1'b1;
               end
            end
         end
         HIGH: begin
            if (ph_q == ha_q) begin
               state_d = LOW;
               ph_d    = 16'd1;
            end else begin
               ph_d = ph_q + 16'd1;
            end
         end
         LOW: begin
            if (ph_q == la_q) begin
               done_c = 1'b1;
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
               if (!gen_en_q || burst_last) begin
                  state_d = STOP;
                  ph_d    = 16'd0;
               end else if (!cfg_legal) begin
                  state_d = STOP;
                  ph_d    = 16'd0;
                  err_d   = 1'b1;
               end else begin
                  state_d = HIGH;
                  ph_d    = 16'd1;
                  load_c  = 1'b1;
               end
            end else begin
               ph_d = ph_q + 16'd1;
            end
         end
         STOP: begin
            state_d = IDLE;
            ph_d    = 16'd0;
         end
         default: state_d = IDLE;
      endcase
      ha_d  = load_c ? h_eff : ha_q;
      la_d  = load_c ? (p_eff - h_eff) : la_q;
      sig_d = (state_d == HIGH);
   end

   // State, active registers and outputs; gen_en is registered first, giving the one-cycle start latency
   always_ff @(posedge clk_1us) begin
      if (rst_i) begin
         state_q  <= IDLE;
         gen_en_q <= 1'b0;
         ha_q     <= 16'd0;
         la_q     <= 16'd0;
         ph_q     <= 16'd0;
         cnt_q    <= 8'd0;
         err_q    <= 1'b0;
         sig_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gen_en_q <= wif.gen_en;
         ha_q     <= ha_d;
         la_q     <= la_d;
         ph_q     <= ph_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         sig_q    <= sig_d;
      end
   end

   assign wif.wmt_sig_o = sig_q;
   assign wif.gen_busy  = (state_q != IDLE);
   assign wif.cyc_done  = done_c;
   assign wif.cyc_cnt   = cnt_q;
   assign wif.cfg_err   = err_q;

endmodule

// File: tb/tb_wmt_gen.sv
// tb_wmt_gen -- directed self-checking bench for wmt_gen. Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
module tb_wmt_gen;

   logic clk_1us = 1'b0;
   logic rst_i   = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   wmt_gen_if wif();

   wmt_gen dut (
      .clk_1us (clk_1us),
      .rst_i   (rst_i),
      .wif     (wif)
   );

   // Free-running 1 us tick clock
   always #5 clk_1us = ~clk_1us;

   // Hard stop in case a wait is never satisfied
   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk_1us);
      #1;
   endtask

   task automatic load_cfg(input logic [15:0] p, input logic [15:0] h, input logic [7:0] n);
      wif.pdn1us_set  = p;
      wif.pdnh1us_set = h;
      wif.ncyc_set    = n;
      wif.cfg_ld      = 1'b1;
      tick();
      wif.cfg_ld      = 1'b0;
   endtask

   // Waits for a high phase, then counts its high and low samples up to the next rise
   task automatic measure_period(input int ldAt, input logic [15:0] ldP, input logic [15:0] ldH,
                                 output int hi, output int lo, output int dones,
                                 output bit lastDone, output bit tmo);
      int n;
      int g;
      hi = 0; lo = 0; dones = 0; lastDone = 1'b0; tmo = 1'b0; n = 0; g = 0;
      while (wif.wmt_sig_o !== 1'b1 && g < 30000) begin
         tick();
         g++;
      end
      if (wif.wmt_sig_o !== 1'b1) tmo = 1'b1;
      while (!tmo) begin
         if (wif.wmt_sig_o === 1'b1 && lo > 0) break;
         n++;
         if (n == ldAt) begin
            wif.pdn1us_set  = ldP;
            wif.pdnh1us_set = ldH;
            wif.cfg_ld      = 1'b1;
         end
         dones += int'(wif.cyc_done);
         if (wif.wmt_sig_o === 1'b1) begin
            hi++;
         end else begin
            lo++;
            lastDone = wif.cyc_done;
         end
         tick();
         wif.cfg_ld = 1'b0;
         if (n > 30000) tmo = 1'b1;
      end
   endtask

   // Drops gen_en and waits for the generator to return to IDLE
   task automatic stop_gen(output bit tmo);
      int g;
      g = 0;
      wif.gen_en = 1'b0;
      while (wif.gen_busy === 1'b1 && g < 40000) begin
         tick();
         g++;
      end
      tmo = (wif.gen_busy !== 1'b0);
      tick();
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      checks++; if (wif.wmt_sig_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_sig: got %0d expected 0", wif.wmt_sig_o); end
      checks++; if (wif.gen_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0d expected 0", wif.gen_busy); end
      checks++; if (wif.cyc_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %0d expected 0", wif.cyc_done); end
      checks++; if (wif.cyc_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_cnt: got %0d expected 0", wif.cyc_cnt); end
      checks++; if (wif.cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %0d expected 0", wif.cfg_err); end
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int hi, lo, dn;
      bit ld, tmo;
      load_cfg(16'd1000, 16'd500, 8'd0);
      wif.gen_en = 1'b1;
      tick();
      checks++; if (wif.wmt_sig_o !== 1'b0) begin failures++; $display("[TB] FAIL start_sample_edge: got %0d expected 0", wif.wmt_sig_o); end
      tick();
      checks++; if (wif.wmt_sig_o !== 1'b1) begin failures++; $display("[TB] FAIL start_rise: got %0d expected 1", wif.wmt_sig_o); end
      checks++; if (wif.gen_busy !== 1'b1) begin failures++; $display("[TB] FAIL start_busy: got %0d expected 1", wif.gen_busy); end
      checks++; if (wif.cyc_cnt !== 8'd0) begin failures++; $display("[TB] FAIL start_cnt: got %0d expected 0", wif.cyc_cnt); end
      measure_period(0, 16'd0, 16'd0, hi, lo, dn, ld, tmo);
      checks++; if (hi !== 500 || tmo) begin failures++; $display("[TB] FAIL p1000_high: got %0d expected 500", hi); end
      checks++; if (lo !== 500) begin failures++; $display("[TB] FAIL p1000_low: got %0d expected 500", lo); end
      checks++; if (dn !== 1 || ld !== 1'b1) begin failures++; $display("[TB] FAIL p1000_done: got count %0d last %0d expected 1 1", dn, ld); end
      measure_period(0, 16'd0, 16'd0, hi, lo, dn, ld, tmo);
      checks++; if (hi + lo !== 1000 || tmo) begin failures++; $display("[TB] FAIL p1000_spacing: got %0d expected 1000", hi + lo); end
      checks++; if (wif.cyc_cnt !== 8'd2) begin failures++; $display("[TB] FAIL p1000_cnt: got %0d expected 2", wif.cyc_cnt); end
      stop_gen(tmo);
      checks++; if (tmo) begin failures++; $display("[TB] FAIL p1000_stop: got busy %0d expected 0", wif.gen_busy); end
   endtask

   task automatic test_narrow();
      int hi, lo, dn;
      bit ld, tmo;
      load_cfg(16'd20, 16'd19, 8'd0);
      wif.gen_en = 1'b1;
      measure_period(5, 16'd2, 16'd1, hi, lo, dn, ld, tmo);
      checks++; if (hi !== 19 || lo !== 1 || tmo) begin failures++; $display("[TB] FAIL p20_h19: got %0d/%0d expected 19/1", hi, lo); end
      checks++; if (dn !== 1 || ld !== 1'b1) begin failures++; $display("[TB] FAIL p20_done: got count %0d last %0d expected 1 1", dn, ld); end
      measure_period(0, 16'd0, 16'd0, hi, lo, dn, ld, tmo);
      checks++; if (hi !== 1 || lo !== 1 || tmo) begin failures++; $display("[TB] FAIL p2_h1_first: got %0d/%0d expected 1/1", hi, lo); end
      measure_period(0, 16'd0, 16'd0, hi, lo, dn, ld, tmo);
      checks++; if (hi !== 1 || lo !== 1 || dn !== 1 || tmo) begin failures++; $display("[TB] FAIL p2_h1_second: got %0d/%0d done %0d expected 1/1 done 1", hi, lo, dn); end
      stop_gen(tmo);
      checks++; if (tmo) begin failures++; $display("[TB] FAIL p2_stop: got busy %0d expected 0", wif.gen_busy); end
   endtask

   task automatic test_illegal();
      int hiN, loN, g;
      load_cfg(16'd100, 16'd0, 8'd0);
      wif.gen_en = 1'b1;
      tick(); tick();
      checks++; if (wif.cfg_err !== 1'b1) begin failures++; $display("[TB] FAIL h0_err: got %0d expected 1", wif.cfg_err); end
      checks++; if (wif.wmt_sig_o !== 1'b0 || wif.gen_busy !== 1'b0) begin failures++; $display("[TB] FAIL h0_idle: got sig %0d busy %0d expected 0 0", wif.wmt_sig_o, wif.gen_busy); end
      wif.gen_en = 1'b0;
      tick(); tick();
      checks++; if (wif.cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL h0_err_clear: got %0d expected 0", wif.cfg_err); end
      load_cfg(16'd25001, 16'd10, 8'd0);
      wif.gen_en = 1'b1;
      tick(); tick(); tick();
      checks++; if (wif.cfg_err !== 1'b1 || wif.gen_busy !== 1'b0 || wif.wmt_sig_o !== 1'b0) begin failures++; $display("[TB] FAIL p25001: got err %0d busy %0d sig %0d expected 1 0 0", wif.cfg_err, wif.gen_busy, wif.wmt_sig_o); end
      wif.gen_en = 1'b0;
      tick(); tick();
      load_cfg(16'd2, 16'd2, 8'd0);
      wif.gen_en = 1'b1;
      tick(); tick();
      checks++; if (wif.cfg_err !== 1'b1 || wif.gen_busy !== 1'b0) begin failures++; $display("[TB] FAIL h_eq_p: got err %0d busy %0d expected 1 0", wif.cfg_err, wif.gen_busy); end
      wif.gen_en = 1'b0;
      tick(); tick();
      // Illegal values loaded mid-period: current period completes, then STOP with error
      load_cfg(16'd20, 16'd10, 8'd0);
      wif.gen_en = 1'b1;
      tick(); tick();
      hiN = (wif.wmt_sig_o === 1'b1) ? 1 : 0;
      loN = 0;
      g = 0;
      load_cfg(16'd20, 16'd0, 8'd0);
      while (wif.gen_busy === 1'b1 && g < 200) begin
         if (wif.wmt_sig_o === 1'b1) hiN++; else loN++;
         tick();
         g++;
      end
      checks++; if (hiN !== 10 || loN !== 11) begin failures++; $display("[TB] FAIL bnd_illegal_period: got %0d/%0d expected 10/11", hiN, loN); end
      checks++; if (wif.cfg_err !== 1'b1 || wif.wmt_sig_o !== 1'b0) begin failures++; $display("[TB] FAIL bnd_illegal_err: got err %0d sig %0d expected 1 0", wif.cfg_err, wif.wmt_sig_o); end
      wif.gen_en = 1'b0;
      tick(); tick();
      checks++; if (wif.cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL bnd_err_clear: got %0d expected 0", wif.cfg_err); end
   endtask

   task automatic test_midperiod_cfg();
      int hi, lo, dn;
      bit ld, tmo;
      load_cfg(16'd100, 16'd50, 8'd0);
      wif.gen_en = 1'b1;
      measure_period(30, 16'd40, 16'd10, hi, lo, dn, ld, tmo);
      checks++; if (hi !== 50 || lo !== 50 || tmo) begin failures++; $display("[TB] FAIL mid_cfg_current: got %0d/%0d expected 50/50", hi, lo); end
      measure_period(40, 16'd20, 16'd5, hi, lo, dn, ld, tmo);
      checks++; if (hi !== 10 || lo !== 30 || tmo) begin failures++; $display("[TB] FAIL mid_cfg_next: got %0d/%0d expected 10/30", hi, lo); end
      measure_period(0, 16'd0, 16'd0, hi, lo, dn, ld, tmo);
      checks++; if (hi !== 5 || lo !== 15 || tmo) begin failures++; $display("[TB] FAIL boundary_ld: got %0d/%0d expected 5/15", hi, lo); end
      stop_gen(tmo);
      checks++; if (tmo) begin failures++; $display("[TB] FAIL mid_cfg_stop: got busy %0d expected 0", wif.gen_busy); end
   endtask

   task automatic test_graceful_stop();
      int n, hi, busyLo, dn;
      bit stayed;
      load_cfg(16'd100, 16'd50, 8'd0);
      wif.gen_en = 1'b1;
      tick(); tick();
      n = 1; hi = 0; busyLo = 0; dn = 0;
      while (wif.gen_busy === 1'b1 && n < 1000) begin
         if (n == 20) wif.gen_en = 1'b0;
         dn += int'(wif.cyc_done);
         if (wif.wmt_sig_o === 1'b1) hi++; else busyLo++;
         tick();
         n++;
      end
      checks++; if (hi !== 50) begin failures++; $display("[TB] FAIL stop_high: got %0d expected 50", hi); end
      checks++; if (busyLo !== 51) begin failures++; $display("[TB] FAIL stop_low_plus_stop: got %0d expected 51", busyLo); end
      checks++; if (dn !== 1 || wif.cyc_cnt !== 8'd1) begin failures++; $display("[TB] FAIL stop_done: got done %0d cnt %0d expected 1 1", dn, wif.cyc_cnt); end
      stayed = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (wif.wmt_sig_o !== 1'b0 || wif.gen_busy !== 1'b0) stayed = 1'b0;
      end
      checks++; if (!stayed) begin failures++; $display("[TB] FAIL stop_stays_idle: got sig %0d busy %0d expected 0 0", wif.wmt_sig_o, wif.gen_busy); end
   endtask

   task automatic test_reset_midhigh();
      int hi, lo, dn;
      bit ld, tmo;
      load_cfg(16'd100, 16'd50, 8'd0);
      wif.gen_en = 1'b1;
      tick(); tick();
      for (int i = 0; i < 9; i++) tick();
      rst_i = 1'b1;
      tick();
      checks++; if (wif.wmt_sig_o !== 1'b0 || wif.gen_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_midhigh: got sig %0d busy %0d expected 0 0", wif.wmt_sig_o, wif.gen_busy); end
      rst_i = 1'b0;
      measure_period(0, 16'd0, 16'd0, hi, lo, dn, ld, tmo);
      checks++; if (hi !== 500 || lo !== 500 || tmo) begin failures++; $display("[TB] FAIL rst_shadow_default: got %0d/%0d expected 500/500", hi, lo); end
      stop_gen(tmo);
      checks++; if (tmo) begin failures++; $display("[TB] FAIL rst_stop: got busy %0d expected 0", wif.gen_busy); end
   endtask

`ifdef WMT_GEN_BURST_EN
   task automatic test_burst();
      int n, rises, dn;
      bit prev, seen, stayed, tmo;
      load_cfg(16'd50, 16'd25, 8'd5);
      wif.gen_en = 1'b1;
      n = 0; rises = 0; dn = 0; prev = 1'b0; seen = 1'b0;
      while (n < 2000) begin
         tick();
         n++;
         if (wif.gen_busy === 1'b1) seen = 1'b1;
         if (seen && wif.gen_busy !== 1'b1) break;
         if (wif.wmt_sig_o === 1'b1 && !prev) rises++;
         prev = wif.wmt_sig_o;
         dn += int'(wif.cyc_done);
      end
      checks++; if (rises !== 5 || dn !== 5) begin failures++; $display("[TB] FAIL burst_pulses: got rises %0d done %0d expected 5 5", rises, dn); end
      checks++; if (wif.cyc_cnt !== 8'd5) begin failures++; $display("[TB] FAIL burst_cnt: got %0d expected 5", wif.cyc_cnt); end
      stayed = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (wif.gen_busy !== 1'b0 || wif.wmt_sig_o !== 1'b0) stayed = 1'b0;
      end
      checks++; if (!stayed) begin failures++; $display("[TB] FAIL burst_hold_idle: got busy %0d expected 0", wif.gen_busy); end
      wif.gen_en = 1'b0;
      tick(); tick();
      wif.gen_en = 1'b1;
      tick(); tick();
      checks++; if (wif.wmt_sig_o !== 1'b1 || wif.cyc_cnt !== 8'd0) begin failures++; $display("[TB] FAIL burst_restart: got sig %0d cnt %0d expected 1 0", wif.wmt_sig_o, wif.cyc_cnt); end
      stop_gen(tmo);
      checks++; if (tmo) begin failures++; $display("[TB] FAIL burst_stop: got busy %0d expected 0", wif.gen_busy); end
   endtask
`else
   task automatic test_continuous();
      int rises;
      bit prev, tmo;
      load_cfg(16'd2, 16'd1, 8'd5);
      wif.gen_en = 1'b1;
      rises = 0; prev = 1'b0;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (wif.wmt_sig_o === 1'b1 && !prev) rises++;
         prev = wif.wmt_sig_o;
      end
      checks++; if (rises !== 300) begin failures++; $display("[TB] FAIL cont_rises: got %0d expected 300", rises); end
      checks++; if (wif.cyc_cnt !== 8'hFF) begin failures++; $display("[TB] FAIL cont_cnt_sat: got %0d expected 255", wif.cyc_cnt); end
      checks++; if (wif.gen_busy !== 1'b1) begin failures++; $display("[TB] FAIL cont_busy: got %0d expected 1", wif.gen_busy); end
      stop_gen(tmo);
      checks++; if (tmo) begin failures++; $display("[TB] FAIL cont_stop: got busy %0d expected 0", wif.gen_busy); end
   endtask
`endif

   // Test sequence
   initial begin
      wif.gen_en      = 1'b0;
      wif.cfg_ld      = 1'b0;
      wif.pdn1us_set  = 16'd0;
      wif.pdnh1us_set = 16'd0;
      wif.ncyc_set    = 8'd0;
      #2;
      test_reset();
      test_basic();
      test_narrow();
      test_illegal();
      test_midperiod_cfg();
      test_graceful_stop();
      test_reset_midhigh();
`ifdef WMT_GEN_BURST_EN
      test_burst();
`else
      test_continuous();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
